sgd_lr_engine: RTL and testbench
================================

# sgd_lr_engine

Clocked, parametrised stochastic-gradient-descent engine for fixed-point linear regression. It streams data rows from an external synchronous RAM over a valid-qualified read port and computes a prediction and error for each row. It then updates the bias and feature weights for a programmable number of epochs and presents the trained weight vector when done. It is the next-generation training core: a configurable multiplier-lane count, a real read handshake, fixed-point scaling and saturation replace the fixed three-multiplier, combinational-state design.

## Interface
- LENGTH, 16, bits per fixed-point word (signed)
- FRAC, 8, fractional bits; 1.0 = 2^FRAC
- MAX_FEATURES, 15, maximum feature count
- NUM_MUL, 3, parallel multiplier lanes (1..MAX_FEATURES)
- ADDR_WIDTH, 12, RAM address width
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1), row/weight vector width

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin training; sampled in IDLE or DONE
- feat  in  4  active feature count, clamped to MAX_FEATURES; latched at start
- data_points  in  ADDR_WIDTH  row count; latched at start
- epoch  in  8  epoch count; latched at start
- learn_rate  in  4  error right-shift amount; latched at start
- rd_en  out  1  single-cycle read request
- rd_addr  out  ADDR_WIDTH  read address, stable while a request is outstanding
- rd_valid  in  1  rd_data valid strobe
- rd_data  in  DATA_WIDTH  slot 0 (MSBs) = y or bias; slots 1..MAX_FEATURES = x or w
- w_out  out  DATA_WIDTH  weight vector, same slot layout
- busy  out  1  high from the start acceptance until DONE
- done  out  1  high in DONE
- epoch_cnt  out  8  completed epochs

## Operation
- Memory map: address 0 holds the initial weights; rows live at addresses 1..data_points.
- States:
  - IDLE: start goes to LOADW.
  - LOADW: read address 0, then W <= rd_data. Goes to DONE if epoch==0 or data_points==0; otherwise FETCH.
  - FETCH: read row dp and latch it.
  - PRED: B = max(1, ceil(feat/NUM_MUL)) beats. Lane k of beat b multiplies x[b*NUM_MUL+k+1] by w[same]. Lanes whose index exceeds feat contribute 0. The accumulator starts at w[0].
  - ERR: err = sat(y − yhat) >>> learn_rate, arithmetic shift.
  - UPD: B beats. w[i] <= sat(w[i] + mul(x[i], err)) for active i. The first beat also does w[0] <= sat(w[0] + err).
  - NEXT: if dp==data_points, then dp<=1 and epoch_cnt++. Goes to DONE if epoch_cnt+1==epoch; otherwise FETCH.
  - DONE: start returns to LOADW.
- mul(a,b) = sat((a*b) >>> FRAC). The full 2*LENGTH-bit product is formed before the shift.
- The accumulator is LENGTH+4 bits wide and is saturated to LENGTH only at ERR.
- Weights at indices above feat are never modified.
- start while busy is ignored.
- Feature inputs are latched at start, so changes mid-run have no effect.

## Timing
- Reset values: rd_en=0, rd_addr=0, w_out=0, busy=0, done=0, epoch_cnt=0; state IDLE.
- Reset mid-operation behaves identically to these reset values. Any outstanding read response is ignored.
- Read handshake:
  - rd_en pulses for exactly one cycle on entry to LOADW or FETCH.
  - The engine waits indefinitely for rd_valid, with latency ≥1 cycle.
  - rd_data is sampled in the rd_valid cycle.
  - rd_valid with no request outstanding is ignored.
- Cycles per row: 1 + L + B + 1 + B + 1, where L is the read latency.
- w_out is registered and tracks W every cycle.
- done asserts in the cycle after NEXT or LOADW decides DONE.

## Configuration
- SGD_SAT_EN defined: every sat() clamps to [−2^(LENGTH−1), 2^(LENGTH−1)−1].
- SGD_SAT_EN undefined: sat() truncates to LENGTH bits (two's-complement wrap). The saturation logic is removed.

## Structure
- Package sgd_pkg holds:
  - the state enumeration;
  - default LENGTH/FRAC constants;
  - the slot-extraction index helper;
  - the sat() function, with its SGD_SAT_EN-guarded body.
- Sub-module sgd_fx_mul: signed multiply, >>> FRAC, sat. It is instantiated NUM_MUL times and shared between PRED and UPD.

## Test plan
- Reset check: assert RST mid-UPD → in the same cycle w_out=0, busy=0, done=0, rd_en=0. The next start restarts from LOADW.
- Single point: FRAC=8, feat=1, W={0,0}, row y=0x0200, x1=0x0100, learn_rate=1, epoch=1, data_points=1 → err=0x0100; w0=0x0100, w1=0x0100; done=1, epoch_cnt=1.
- Read latency: repeat the single-point case with rd_valid delayed 1 and then 4 cycles → identical w_out. Cycles per row differ by exactly 3.
- Lane coverage: NUM_MUL=3, feat=4, all x=0x0100, W=0, y=0x0100, lr=0 → B=2; w0..w4=0x0100; w5..w15 unchanged.
- Saturation (SGD_SAT_EN): w1=0x7F00, x1=0x7F00, y=0 → yhat clamps to 0x7FFF and err=0x8001. Without the macro, the value wraps per truncation.
- Epoch/row wrap: data_points=3, epoch=2 → rd_addr sequence 0,1,2,3,1,2,3; epoch_cnt steps to 2; rd_en never pulses after done.

Source files
------------

// File: rtl/sgd_pkg.sv
// Shared types and fixed-point helpers for the SGD linear-regression engine.
// SGD_SAT_EN selects clamping saturation; otherwise sat() wraps to LENGTH bits.
package sgd_pkg;

    localparam int unsigned SGD_LENGTH = 16;
    localparam int unsigned SGD_FRAC   = 8;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOADW = 4'd1,
        ST_FETCH = 4'd2,
        ST_PRED  = 4'd3,
        ST_ERR   = 4'd4,
        ST_UPD   = 4'd5,
        ST_NEXT  = 4'd6,
        ST_DONE  = 4'd7
    } sgd_state_e;

    // Slot 0 sits in the MSBs of a packed row/weight vector.
    function automatic int unsigned slot_lsb(input int unsigned slot,
                                             input int unsigned nslots,
                                             input int unsigned len);
        return (nslots - 1 - slot) * len;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int unsigned len);
`ifdef SGD_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (len - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        return (v <<< (64 - len)) >>> (64 - len);
`endif
    endfunction

endpackage

// File: rtl/sgd_fx_mul.sv
// Fixed-point multiplier lane: full-width signed product, >>> FRAC, then sat().
// Saturation behaviour follows SGD_SAT_EN through sgd_pkg::sat.
module sgd_fx_mul
    import sgd_pkg::*;
#(
    parameter int unsigned LENGTH = SGD_LENGTH,
    parameter int unsigned FRAC   = SGD_FRAC
) (
    input  logic signed [LENGTH-1:0] a,
    input  logic signed [LENGTH-1:0] b,
    output logic signed [LENGTH-1:0] p
);

    logic signed [2*LENGTH-1:0] prod;
    logic signed [63:0]         shifted;

    always_comb begin
        prod    = a * b;
        shifted = 64'(prod >>> FRAC);
        p       = LENGTH'(sat(shifted, LENGTH));
    end

endmodule

// File: rtl/sgd_lr_engine.sv
// SGD linear-regression training core streaming rows from a synchronous RAM.
// Build with SGD_SAT_EN defined for clamping arithmetic; default wraps.
module sgd_lr_engine
    import sgd_pkg::*;
#(
    parameter int unsigned LENGTH       = SGD_LENGTH,
    parameter int unsigned FRAC         = SGD_FRAC,
    parameter int unsigned MAX_FEATURES = 15,
    parameter int unsigned NUM_MUL      = 3,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [3:0]            feat,
    input  logic [ADDR_WIDTH-1:0] data_points,
    input  logic [7:0]            epoch,
    input  logic [3:0]            learn_rate,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            epoch_cnt
);

    localparam int unsigned NSLOT = MAX_FEATURES + 1;
    localparam int unsigned AW    = LENGTH + 4;
    localparam int unsigned IW    = $clog2(NSLOT);

    sgd_state_e state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  pend_q, pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [7:0]            epoch_cnt_q, epoch_cnt_d;
    logic [7:0]            feat_q, feat_d;
    logic [7:0]            nbeat_q, nbeat_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            epoch_q, epoch_d;
    logic [3:0]            lr_q, lr_d;
    logic [ADDR_WIDTH-1:0] npts_q, npts_d;
    logic [ADDR_WIDTH-1:0] dp_q, dp_d;
    logic signed [LENGTH-1:0] w_q [NSLOT];
    logic signed [LENGTH-1:0] w_d [NSLOT];
    logic signed [LENGTH-1:0] x_q [NSLOT];
    logic signed [LENGTH-1:0] x_d [NSLOT];
    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [LENGTH-1:0] err_q, err_d;
    logic [DATA_WIDTH-1:0]    w_out_q, w_out_d;

    logic signed [LENGTH-1:0] row_in [NSLOT];
    logic [7:0]               feat_clamp;
    logic [7:0]               nbeat_tmp;
    logic [7:0]               nbeat_calc;
    logic [7:0]               lane_idx [NUM_MUL];
    logic [IW-1:0]            lane_sel [NUM_MUL];
    logic                     lane_act [NUM_MUL];
    logic signed [LENGTH-1:0] lane_a [NUM_MUL];
    logic signed [LENGTH-1:0] lane_b [NUM_MUL];
    logic signed [LENGTH-1:0] lane_p [NUM_MUL];
    logic signed [AW-1:0]     lane_sum;
    logic signed [LENGTH-1:0] yhat;
    logic signed [LENGTH-1:0] err_diff;
    logic signed [LENGTH-1:0] err_calc;

    always_comb begin
        for (int unsigned i = 0; i < NSLOT; i++)
            row_in[i] = rd_data[slot_lsb(i, NSLOT, LENGTH) +: LENGTH];
        feat_clamp = (32'(feat) > MAX_FEATURES) ? 8'(MAX_FEATURES) : 8'(feat);
        nbeat_tmp  = 8'((32'(feat_clamp) + NUM_MUL - 1) / NUM_MUL);
        nbeat_calc = (nbeat_tmp == 8'd0) ? 8'd1 : nbeat_tmp;
    end

    // Lanes are shared: PRED multiplies x by w, UPD multiplies x by err.
    always_comb begin
        lane_sum = AW'(0);
        for (int unsigned k = 0; k < NUM_MUL; k++) begin
            lane_idx[k] = 8'(beat_q * NUM_MUL + k + 1);
            lane_act[k] = (lane_idx[k] <= feat_q);
            lane_sel[k] = lane_act[k] ? IW'(lane_idx[k]) : '0;
            lane_a[k]   = lane_act[k] ? x_q[lane_sel[k]] : '0;
            if (!lane_act[k])
                lane_b[k] = '0;
            else if (state_q == ST_UPD)
                lane_b[k] = err_q;
            else
                lane_b[k] = w_q[lane_sel[k]];
            lane_sum = lane_sum + AW'(lane_p[k]);
        end
    end

    for (genvar g = 0; g < NUM_MUL; g++) begin : g_lane
        sgd_fx_mul #(.LENGTH(LENGTH), .FRAC(FRAC)) u_mul (
            .a (lane_a[g]),
            .b (lane_b[g]),
            .p (lane_p[g])
        );
    end

    always_comb begin
        yhat     = LENGTH'(sat(64'(acc_q), LENGTH));
        err_diff = LENGTH'(sat(64'(x_q[0]) - 64'(yhat), LENGTH));
        err_calc = err_diff >>> lr_q;
    end

    always_comb begin
        state_d     = state_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        pend_d      = pend_q;
        busy_d      = busy_q;
        done_d      = done_q;
        epoch_cnt_d = epoch_cnt_q;
        feat_d      = feat_q;
        nbeat_d     = nbeat_q;
        beat_d      = beat_q;
        epoch_d     = epoch_q;
        lr_d        = lr_q;
        npts_d      = npts_q;
        dp_d        = dp_q;
        w_d         = w_q;
        x_d         = x_q;
        acc_d       = acc_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOADW;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = '0;
                    pend_d      = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    epoch_cnt_d = '0;
                    feat_d      = feat_clamp;
                    nbeat_d     = nbeat_calc;
                    epoch_d     = epoch;
                    lr_d        = learn_rate;
                    npts_d      = data_points;
                end
            end
            ST_LOADW: begin
                if (rd_valid && pend_q) begin
                    pend_d = 1'b0;
                    w_d    = row_in;
                    if (epoch_q == 8'd0 || npts_q == '0) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_FETCH;
                        rd_en_d   = 1'b1;
                        rd_addr_d = ADDR_WIDTH'(1);
                        dp_d      = ADDR_WIDTH'(1);
                        pend_d    = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (rd_valid && pend_q) begin
                    pend_d  = 1'b0;
                    x_d     = row_in;
                    beat_d  = '0;
                    acc_d   = AW'(w_q[0]);
                    state_d = ST_PRED;
                end
            end
            ST_PRED: begin
                acc_d = acc_q + lane_sum;
                if (beat_q == nbeat_q - 8'd1)
                    state_d = ST_ERR;
                else
                    beat_d = beat_q + 8'd1;
            end
            ST_ERR: begin
                err_d   = err_calc;
                beat_d  = '0;
                state_d = ST_UPD;
            end
            ST_UPD: begin
                for (int unsigned k = 0; k < NUM_MUL; k++) begin
                    if (lane_act[k])
                        w_d[lane_sel[k]] = LENGTH'(sat(64'(w_q[lane_sel[k]]) + 64'(lane_p[k]), LENGTH));
                end
                if (beat_q == 8'd0)
                    w_d[0] = LENGTH'(sat(64'(w_q[0]) + 64'(err_q), LENGTH));
                if (beat_q == nbeat_q - 8'd1)
                    state_d = ST_NEXT;
                else
                    beat_d = beat_q + 8'd1;
            end
            ST_NEXT: begin
                if (dp_q == npts_q) begin
                    dp_d        = ADDR_WIDTH'(1);
                    epoch_cnt_d = epoch_cnt_q + 8'd1;
                    if (epoch_cnt_q + 8'd1 == epoch_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_FETCH;
                        rd_en_d   = 1'b1;
                        rd_addr_d = ADDR_WIDTH'(1);
                        pend_d    = 1'b1;
                    end
                end else begin
                    dp_d      = dp_q + ADDR_WIDTH'(1);
                    state_d   = ST_FETCH;
                    rd_en_d   = 1'b1;
                    rd_addr_d = dp_q + ADDR_WIDTH'(1);
                    pend_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_out_d = '0;
        for (int unsigned i = 0; i < NSLOT; i++)
            w_out_d[slot_lsb(i, NSLOT, LENGTH) +: LENGTH] = w_q[i];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            epoch_cnt_q <= '0;
            feat_q      <= '0;
            nbeat_q     <= 8'd1;
            beat_q      <= '0;
            epoch_q     <= '0;
            lr_q        <= '0;
            npts_q      <= '0;
            dp_q        <= '0;
            acc_q       <= '0;
            err_q       <= '0;
            w_out_q     <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pend_q      <= pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            epoch_cnt_q <= epoch_cnt_d;
            feat_q      <= feat_d;
            nbeat_q     <= nbeat_d;
            beat_q      <= beat_d;
            epoch_q     <= epoch_d;
            lr_q        <= lr_d;
            npts_q      <= npts_d;
            dp_q        <= dp_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            w_out_q     <= w_out_d;
            w_q         <= w_d;
            x_q         <= x_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign w_out     = w_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign epoch_cnt = epoch_cnt_q;

endmodule

// File: tb/tb_sgd_lr_engine.sv
// Directed bench for sgd_lr_engine with a latency-programmable RAM model.
// Saturation expectations follow SGD_SAT_EN when the bench is built with it.
module tb_sgd_lr_engine;

    localparam int LENGTH = 16;
    localparam int NSLOT  = 16;
    localparam int AWID   = 12;
    localparam int DW     = LENGTH * NSLOT;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            start = 1'b0;
    logic [3:0]      feat = '0;
    logic [AWID-1:0] data_points = '0;
    logic [7:0]      epoch = '0;
    logic [3:0]      learn_rate = '0;
    logic            rd_en;
    logic [AWID-1:0] rd_addr;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   w_out;
    logic            busy;
    logic            done;
    logic [7:0]      epoch_cnt;

    sgd_lr_engine #(
        .LENGTH(16), .FRAC(8), .MAX_FEATURES(15), .NUM_MUL(3), .ADDR_WIDTH(12)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .feat(feat), .data_points(data_points),
        .epoch(epoch), .learn_rate(learn_rate), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .w_out(w_out), .busy(busy),
        .done(done), .epoch_cnt(epoch_cnt)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0]   mem [16];
    int              lat = 1;
    int              cyc = 0;
    int              last_en_cyc = 0;
    int              en_count = 0;
    logic [AWID-1:0] addr_log [$];
    logic [7:0]      ec_log [$];
    int              n_checks = 0;
    int              n_errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin : ram_model
        logic [AWID-1:0] a;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(posedge CLK);
            #1;
            rd_valid = 1'b0;
            if (rd_en) begin
                a = rd_addr;
                en_count++;
                last_en_cyc = cyc;
                addr_log.push_back(a);
                ec_log.push_back(epoch_cnt);
                repeat (lat) @(posedge CLK);
                #1;
                rd_valid = 1'b1;
                rd_data  = mem[a[3:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] sv(input logic [DW-1:0] v, input int s, input logic [15:0] x);
        v[(NSLOT-1-s)*LENGTH +: LENGTH] = x;
        return v;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = '0;
    endtask

    task automatic put(input int a, input int s, input logic [15:0] x);
        mem[a] = sv(mem[a], s, x);
    endtask

    task automatic kick(input logic [3:0] f, input logic [AWID-1:0] dp,
                        input logic [7:0] ep, input logic [3:0] lr);
        @(posedge CLK);
        #1;
        feat = f; data_points = dp; epoch = ep; learn_rate = lr;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int done_cyc);
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge CLK);
            #1;
        end
        done_cyc = cyc;
        check({tag, "_done"}, done, 1);
    endtask

    logic [DW-1:0]   e;
    logic [DW-1:0]   w_lat1;
    logic [AWID-1:0] exp_addr [7];
    int              dcyc, row1, row4, row_l, en0, base;

    initial begin
        clear_mem();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_w_out", w_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_epoch_cnt", epoch_cnt, 0);
        RST = 1'b0;

        // single point, latency 1
        put(1, 0, 16'h0200); put(1, 1, 16'h0100);
        lat = 1;
        kick(4'd1, 12'd1, 8'd1, 4'd1);
        wait_done("sp1", dcyc);
        row1 = dcyc - last_en_cyc;
        e = sv(sv('0, 0, 16'h0100), 1, 16'h0100);
        check("sp1_w_out", w_out, e);
        check("sp1_busy", busy, 0);
        check("sp1_epoch_cnt", epoch_cnt, 1);
        check("sp1_row_cyc", row1, 6);
        w_lat1 = w_out;

        // single point, latency 4, start pulsed mid-PRED must be ignored
        lat = 4;
        en0 = en_count;
        kick(4'd1, 12'd1, 8'd1, 4'd1);
        repeat (9) @(posedge CLK);
        #1;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done("sp4", dcyc);
        row4 = dcyc - last_en_cyc;
        check("sp4_w_out", w_out, w_lat1);
        check("sp4_row_cyc", row4, 9);
        check("sp4_row_delta", row4 - row1, 3);
        check("sp4_busy_start_ignored", en_count - en0, 2);

        // lane coverage: feat=4 over two beats, feat changed after start
        clear_mem();
        for (int i = 5; i < 16; i++) put(0, i, 16'(16'h0010 + i));
        put(1, 0, 16'h0100);
        for (int i = 1; i < 16; i++) put(1, i, 16'h0100);
        lat = 1;
        kick(4'd4, 12'd1, 8'd1, 4'd0);
        feat = 4'd15;
        wait_done("lane", dcyc);
        row_l = dcyc - last_en_cyc;
        e = '0;
        for (int i = 0; i < 5; i++) e = sv(e, i, 16'h0100);
        for (int i = 5; i < 16; i++) e = sv(e, i, 16'(16'h0010 + i));
        check("lane_w_out", w_out, e);
        check("lane_row_cyc", row_l, 8);

        // overflow path
        clear_mem();
        put(0, 1, 16'h7F00);
        put(1, 0, 16'h0000); put(1, 1, 16'h7F00);
        kick(4'd1, 12'd1, 8'd1, 4'd0);
        wait_done("sat", dcyc);
`ifdef SGD_SAT_EN
        e = sv(sv('0, 0, 16'h8001), 1, 16'hFF00);
`else
        e = sv(sv('0, 0, 16'hFF00), 1, 16'h0000);
`endif
        check("sat_w_out", w_out, e);

        // epoch and row wrap
        clear_mem();
        put(0, 1, 16'h0123);
        for (int r = 1; r <= 3; r++) put(r, 0, 16'h0100);
        addr_log.delete();
        ec_log.delete();
        kick(4'd1, 12'd3, 8'd2, 4'd2);
        wait_done("wrap", dcyc);
        exp_addr = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd1, 12'd2, 12'd3};
        check("wrap_req_count", addr_log.size(), 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("wrap_addr%0d", i), (i < addr_log.size()) ? addr_log[i] : 'x, exp_addr[i]);
        check("wrap_ec_mid", (ec_log.size() > 4) ? ec_log[4] : 'x, 1);
        check("wrap_epoch_cnt", epoch_cnt, 2);
        check("wrap_w_out", w_out, sv(sv('0, 0, 16'h00D2), 1, 16'h0123));
        en0 = en_count;
        repeat (20) @(posedge CLK);
        #1;
        check("wrap_no_rd_after_done", en_count - en0, 0);

        // asynchronous reset while in UPD, then restart
        clear_mem();
        put(0, 0, 16'h1234);
        put(1, 0, 16'h0200); put(1, 1, 16'h0100);
        lat = 1;
        kick(4'd1, 12'd1, 8'd1, 4'd1);
        repeat (6) @(posedge CLK);
        #1;
        check("pre_rst_w_out", w_out, sv('0, 0, 16'h1234));
        RST = 1'b1;
        #1;
        check("mid_rst_w_out", w_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_en", rd_en, 0);
        check("mid_rst_epoch_cnt", epoch_cnt, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        base = addr_log.size();
        kick(4'd1, 12'd1, 8'd1, 4'd1);
        wait_done("restart", dcyc);
        check("restart_first_addr", (addr_log.size() > base) ? addr_log[base] : 'x, 0);
        check("restart_w_out", w_out, sv(sv('0, 0, 16'h0A1A), 1, 16'hF7E6));
        check("restart_epoch_cnt", epoch_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
